im_sync_bank: RTL and testbench
===============================

Name: im_sync_bank

Overview:
- Parametrised, fully synchronous instruction memory for the pipeline fetch stage.
- Successor to the combinational IM: registered read with one-cycle latency, stall hold, and a hardware clear sweep after reset.
- Adds a program-load write port and out-of-range detection.
- Sits between the IF-stage PC logic and the IF/ID register.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 1024, number of words; need not be a power of 2; minimum 2.
- ADDR_W, 10, word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- IM_read  in  1  fetch request.
- IM_addr  in  ADDR_W  word address of the fetch.
- IM_stall  in  1  pipeline stall; holds all read outputs.
- IM_out  out  DATA_W  registered instruction word.
- IM_valid  out  1  IM_out holds the result of a fetch accepted last cycle (or held under stall).
- IM_err  out  1  the accepted fetch was out of range.
- IM_busy  out  1  clear sweep in progress; fetches and loads ignored.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  load word address.
- load_data  in  DATA_W  load word.
- load_pinj  in  1  parity-error injection on the load; used only with IM_PARITY_EN.
- IM_perr  out  1  parity error on the accepted fetch; constant 0 without IM_PARITY_EN.

Behaviour:
- Reset (asynchronous, active-high): IM_out=0, IM_valid=0, IM_err=0, IM_perr=0, IM_busy=1, state=INIT, clear counter=0. Memory contents are not reset asynchronously.
- INIT state:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - On the cycle that writes cnt==DEPTH-1, next state is READY.
  - IM_busy is 1 for exactly DEPTH cycles after reset release, then 0.
  - IM_read and load_en are ignored in INIT. Read outputs stay at reset values.
- READY state (terminal until the next reset):
  - Accepted fetch (IM_read=1, IM_stall=0, IM_addr<DEPTH): next edge IM_out<=mem[IM_addr], IM_valid<=1, IM_err<=0. Latency is 1 cycle.
  - Out-of-range fetch (IM_read=1, IM_stall=0, IM_addr>=DEPTH): next edge IM_out<=0, IM_valid<=1, IM_err<=1. No memory access.
  - IM_stall=1 (regardless of IM_read): IM_out, IM_valid, IM_err and IM_perr all hold.
  - IM_read=0 and IM_stall=0: IM_valid<=0, IM_err<=0, IM_perr<=0. IM_out holds its last value.
- Load port:
  - load_en=1 in READY with load_addr<DEPTH writes mem[load_addr]<=load_data at the edge.
  - An out-of-range load is silently dropped.
  - Loads are independent of IM_stall.
- Fetch and load to the same address in the same cycle: read-before-write. IM_out gets the old word; the new word is visible from the next fetch.
- Reset mid-INIT or mid-READY restarts the full clear sweep from cnt=0.
- Width rule: address comparisons are unsigned on ADDR_W bits. DEPTH is compared as an ADDR_W+1-bit constant.

Optional Feature:
- Macro: IM_PARITY_EN.
- With the macro defined:
  - Each word stores one extra even-parity bit.
  - The clear sweep writes parity 0.
  - A load stores parity = ^load_data XOR load_pinj.
  - An accepted in-range fetch sets IM_perr<=(^word != stored parity).
  - Out-of-range fetches set IM_perr<=0. IM_perr holds under stall.
  - The error does not alter IM_out or IM_valid.
- Without the macro: no parity storage, load_pinj is ignored, IM_perr is tied to 0.

Test Plan (DEPTH=16, ADDR_W=5, DATA_W=32):
- Release reset -> IM_busy=1 for exactly 16 cycles then 0. A fetch of addr 3 right after returns IM_out=0x00000000, IM_valid=1, IM_err=0.
- Load addr 5=0xDEADBEEF, next cycle fetch addr 5 -> one cycle later IM_out=0xDEADBEEF, IM_valid=1. Same-cycle load 0x12345678 + fetch of addr 5 -> IM_out=0xDEADBEEF; next fetch -> 0x12345678.
- Fetch addr 20 -> IM_out=0, IM_valid=1, IM_err=1. Load to addr 20 -> no memory word changes (all 16 read back unchanged).
- Fetch addr 5 (0xDEADBEEF), then IM_stall=1 for 3 cycles while IM_addr=6 and IM_read=1 -> IM_out stays 0xDEADBEEF and IM_valid stays 1 throughout. Release stall -> next cycle shows mem[6].
- Assert rst 5 cycles into INIT, release -> busy lasts a fresh 16 cycles. Loads during busy are dropped: the word reads 0 afterwards.
- IM_PARITY_EN: load addr 2=0x00000001 with load_pinj=1 -> fetch gives IM_perr=1. Reload with load_pinj=0 -> IM_perr=0. Macro off -> IM_perr always 0.

Source files
------------

// File: rtl/im_sync_bank.sv
// im_sync_bank: registered instruction memory with post-reset clear sweep, program-load port
// and range checking; define IM_PARITY_EN to store and check an even-parity bit per word.
module im_sync_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_read,
  input  logic [ADDR_W-1:0] IM_addr,
  input  logic              IM_stall,
  output logic [DATA_W-1:0] IM_out,
  output logic              IM_valid,
  output logic              IM_err,
  output logic              IM_busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_pinj,
  output logic              IM_perr
);
  typedef enum logic {INIT, READY} state_t;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, w_waddr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out, w_wdata;
  logic              r_valid, r_err, w_rd_ok, w_ld_ok, w_we, w_upd, w_init;
  assign w_init  = r_state == INIT;
  assign w_rd_ok = {1'b0, IM_addr} < DEPTH_C;
  assign w_ld_ok = {1'b0, load_addr} < DEPTH_C;
  assign w_upd   = !w_init && !IM_stall;
  always_comb begin
    w_next  = r_state;
    w_we    = load_en && w_ld_ok;
    w_waddr = load_addr;
    w_wdata = load_data;
    IM_busy = 1'b0;
    if (w_init) begin
      w_next  = r_cnt == LAST ? READY : INIT;
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = '0;
      IM_busy = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_init) r_cnt <= r_cnt + 1'b1;
    end
  // read-before-write on a same-address fetch/load falls out of the non-blocking update
  always_ff @(posedge clk)
    if (w_we) r_mem[w_waddr] <= w_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_upd) begin
      r_valid <= IM_read;
      r_err   <= IM_read && !w_rd_ok;
      if (IM_read) r_out <= w_rd_ok ? r_mem[IM_addr] : '0;
    end
  assign IM_out   = r_out;
  assign IM_valid = r_valid;
  assign IM_err   = r_err;
`ifdef IM_PARITY_EN
  logic r_par [DEPTH];
  logic r_perr;
  always_ff @(posedge clk)
    if (w_we) r_par[w_waddr] <= w_init ? 1'b0 : (^load_data) ^ load_pinj;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_perr <= 1'b0;
    else if (w_upd) r_perr <= IM_read && w_rd_ok && ((^r_mem[IM_addr]) != r_par[IM_addr]);
  assign IM_perr = r_perr;
`else
  logic w_unused_pinj;
  assign w_unused_pinj = load_pinj;
  assign IM_perr       = 1'b0;
`endif
endmodule

// File: tb/tb_im_sync_bank.sv
// tb_im_sync_bank: table-driven check of im_sync_bank (DEPTH=16) with a scoreboard queue,
// plus hand-written reset/clear-sweep sequences.
module tb_im_sync_bank;
  localparam int DW = 32, DP = 16, AW = 5;
  logic          clk = 0, rst = 1, IM_read = 0, IM_stall = 0, load_en = 0, load_pinj = 0;
  logic [AW-1:0] IM_addr = '0, load_addr = '0;
  logic [DW-1:0] load_data = '0, IM_out;
  logic          IM_valid, IM_err, IM_busy, IM_perr;
  int            n_vec = 0, n_bad = 0;
  typedef struct {
    bit rd; logic [AW-1:0] addr; bit stall;
    bit ld; logic [AW-1:0] laddr; logic [DW-1:0] ldata; bit pinj;
    logic [DW-1:0] e_out; bit e_v, e_e, e_p;
  } vec_t;
  typedef struct { logic [DW-1:0] out; bit v, e, p; } exp_t;
  exp_t          sb[$];
  vec_t          tbl[27];
  logic [DW-1:0] model[DP];

  always #5 clk = ~clk;

  im_sync_bank #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .IM_read(IM_read), .IM_addr(IM_addr), .IM_stall(IM_stall),
    .IM_out(IM_out), .IM_valid(IM_valid), .IM_err(IM_err), .IM_busy(IM_busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_pinj(load_pinj), .IM_perr(IM_perr)
  );

  function automatic vec_t v(bit rd, int addr, bit stall, bit ld, int laddr, logic [DW-1:0] ldata,
                             bit pinj, logic [DW-1:0] eo, bit ev, bit ee, bit ep);
    vec_t t;
    t.rd = rd; t.addr = AW'(addr); t.stall = stall;
    t.ld = ld; t.laddr = AW'(laddr); t.ldata = ldata; t.pinj = pinj;
    t.e_out = eo; t.e_v = ev; t.e_e = ee;
`ifdef IM_PARITY_EN
    t.e_p = ep;
`else
    t.e_p = 1'b0 & ep;
`endif
    return t;
  endfunction

  task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(vec_t t, string name);
    exp_t e;
    IM_read = t.rd; IM_addr = t.addr; IM_stall = t.stall;
    load_en = t.ld; load_addr = t.laddr; load_data = t.ldata; load_pinj = t.pinj;
    sb.push_back('{t.e_out, t.e_v, t.e_e, t.e_p});
    if (t.ld && t.laddr < AW'(DP)) model[t.laddr] = t.ldata;
    @(posedge clk); #1;
    IM_read = 0; IM_stall = 0; load_en = 0; load_pinj = 0;
    e = sb.pop_front();
    check({name, " out"},   IM_out,   e.out);
    check({name, " valid"}, {31'b0, IM_valid}, {31'b0, e.v});
    check({name, " err"},   {31'b0, IM_err},   {31'b0, e.e});
    check({name, " perr"},  {31'b0, IM_perr},  {31'b0, e.p});
    check({name, " busy"},  {31'b0, IM_busy},  32'd0);
  endtask

  task automatic sweep(bit noise);
    int n = 0;
    load_en = noise; load_addr = 5'd9; load_data = 32'h55; IM_read = noise; IM_addr = 5'd3;
    while (IM_busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    load_en = 0; IM_read = 0;
    check("busy_len", n, 32'd16);
    check("busy_rd_ignored", {31'b0, IM_valid}, 32'd0);
  endtask

  initial begin
    foreach (model[i]) model[i] = '0;
    tbl[0]  = v(1, 3, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    tbl[1]  = v(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 32'h0, 0, 0, 0);
    tbl[2]  = v(1, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[3]  = v(1, 5, 0, 1, 5, 32'h12345678, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[4]  = v(1, 5, 0, 0, 0, 0, 0, 32'h12345678, 1, 0, 0);
    tbl[5]  = v(1, 20, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
    tbl[6]  = v(0, 0, 0, 1, 20, 32'hAAAA5555, 0, 32'h0, 0, 0, 0);
    tbl[7]  = v(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 32'h0, 0, 0, 0);
    tbl[8]  = v(1, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[9]  = v(1, 6, 1, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[10] = v(1, 6, 1, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[11] = v(1, 6, 1, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[12] = v(1, 6, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    tbl[13] = v(1, 20, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
    tbl[14] = v(0, 0, 1, 0, 0, 0, 0, 32'h0, 1, 1, 0);
    tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    tbl[16] = v(0, 0, 1, 1, 7, 32'hCAFEF00D, 0, 32'h0, 0, 0, 0);
    tbl[17] = v(1, 7, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1, 0, 0);
    tbl[18] = v(0, 0, 0, 1, 15, 32'h0F0F0F0F, 0, 32'hCAFEF00D, 0, 0, 0);
    tbl[19] = v(1, 15, 0, 0, 0, 0, 0, 32'h0F0F0F0F, 1, 0, 0);
    tbl[20] = v(1, 16, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
    tbl[21] = v(1, 31, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
    tbl[22] = v(0, 0, 0, 1, 2, 32'h1, 1, 32'h0, 0, 0, 0);
    tbl[23] = v(1, 2, 0, 0, 0, 0, 0, 32'h1, 1, 0, 1);
    tbl[24] = v(0, 0, 1, 0, 0, 0, 0, 32'h1, 1, 0, 1);
    tbl[25] = v(0, 0, 0, 1, 2, 32'h1, 0, 32'h1, 0, 0, 0);
    tbl[26] = v(1, 2, 0, 0, 0, 0, 0, 32'h1, 1, 0, 0);
    #12;
    check("rst out", IM_out, 32'h0);
    check("rst valid", {31'b0, IM_valid}, 32'd0);
    check("rst err", {31'b0, IM_err}, 32'd0);
    check("rst perr", {31'b0, IM_perr}, 32'd0);
    check("rst busy", {31'b0, IM_busy}, 32'd1);
    @(posedge clk); #1;
    rst = 0;
    sweep(0);
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < DP; i++)
      apply(v(1, i, 0, 0, 0, 0, 0, model[i], 1, 0, 0), $sformatf("readback%0d", i));
    rst = 1; #1;
    check("rst2 valid", {31'b0, IM_valid}, 32'd0);
    check("rst2 out", IM_out, 32'h0);
    check("rst2 busy", {31'b0, IM_busy}, 32'd1);
    @(posedge clk); #1;
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_init busy", {31'b0, IM_busy}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sweep(1);
    foreach (model[i]) model[i] = '0;
    apply(v(1, 9, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0), "busy_load_dropped");
    apply(v(1, 5, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0), "sweep_cleared5");
    apply(v(1, 7, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0), "sweep_cleared7");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
